// File: rtl/gnr_node_array.sv
// Array of independent gene-regulatory-network nodes. Each stream holds one
// boolean state that is recomputed from its regulator inputs every (div+1)-th start.
module gnr_node_array #(
  parameter int NUM_STREAMS = 2,
  parameter int NUM_INPUTS  = 1,
  parameter int DIV_W       = 4,
  parameter int CNT_W       = 8,
  parameter int STABLE_N    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             reset_nos,
  input  logic [NUM_STREAMS-1:0]           init_state,
  input  logic [NUM_STREAMS*DIV_W-1:0]     div_cfg,
  input  logic [NUM_STREAMS-1:0]           start,
  input  logic [1:0]                       mode,
  input  logic [NUM_STREAMS*NUM_INPUTS-1:0] reg_in,
  output logic [NUM_STREAMS-1:0]           state,
  output logic [NUM_STREAMS-1:0]           stable,
  output logic [NUM_STREAMS*CNT_W-1:0]     toggles
);

  typedef enum logic [1:0] {
    MODE_NOR  = 2'd0,
    MODE_AND  = 2'd1,
    MODE_OR   = 2'd2,
    MODE_NAND = 2'd3
  } node_mode_e;

  // The stability counter only has to reach STABLE_N, which is at most 255.
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_N);

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_stream
    logic [NUM_INPUTS-1:0] x;
    logic [DIV_W-1:0]      div_reg;
    logic [DIV_W-1:0]      phase;
    logic [7:0]            stable_cnt;
    logic [CNT_W-1:0]      tog_cnt;
    logic                  cur_state;
    logic                  stable_q;
    logic                  nxt_state;
    logic                  do_update;

    assign x         = reg_in[s*NUM_INPUTS +: NUM_INPUTS];
    assign do_update = start[s] && (phase == div_reg);

    // NOTE: every variable written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
      nxt_state = 1'b0;
      unique case (node_mode_e'(mode))
        MODE_NOR:  nxt_state = ~|x;
        MODE_AND:  nxt_state =  &x;
        MODE_OR:   nxt_state =  |x;
        MODE_NAND: nxt_state = ~&x;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        cur_state  <= 1'b0;
        stable_q   <= 1'b0;
        tog_cnt    <= '0;
        phase      <= '0;
        div_reg    <= '0;
        stable_cnt <= '0;
      end else if (reset_nos) begin
        cur_state  <= init_state[s];
        div_reg    <= div_cfg[s*DIV_W +: DIV_W];
        phase      <= div_cfg[s*DIV_W +: DIV_W];
        tog_cnt    <= '0;
        stable_cnt <= '0;
        stable_q   <= 1'b0;
      end else if (do_update) begin
        phase     <= '0;
        cur_state <= nxt_state;
        if (nxt_state != cur_state) begin
          if (tog_cnt != '1) tog_cnt <= tog_cnt + CNT_W'(1);
          stable_cnt <= '0;
          stable_q   <= 1'b0;
        end else if (stable_cnt != STABLE_MAX) begin
          stable_cnt <= stable_cnt + 8'd1;
          stable_q   <= (stable_cnt + 8'd1 == STABLE_MAX);
        end
      end else if (start[s]) begin
        // Phase-only advance: outputs and stability tracking are untouched.
        phase <= phase + DIV_W'(1);
      end
    end

    assign state[s]                  = cur_state;
    assign stable[s]                 = stable_q;
    assign toggles[s*CNT_W +: CNT_W] = tog_cnt;
  end

endmodule

// File: tb/tb_gnr_node_array.sv
// Self-checking bench: two gnr_node_array configurations compared cycle by
// cycle against an arithmetic reference model, plus directed scenario checks.
module tb_gnr_node_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset_nos;
  logic [1:0] init_state;
  logic [1:0] start;
  logic [1:0] mode;

  logic [7:0]  a_div_cfg;
  logic [1:0]  a_reg_in;
  logic [1:0]  a_state, a_stable;
  logic [15:0] a_toggles;

  logic [5:0] b_div_cfg;
  logic [5:0] b_reg_in;
  logic [1:0] b_state, b_stable;
  logic [3:0] b_toggles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gnr_node_array u_dut_a (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .div_cfg(a_div_cfg), .start(start), .mode(mode), .reg_in(a_reg_in),
    .state(a_state), .stable(a_stable), .toggles(a_toggles)
  );

  gnr_node_array #(
    .NUM_STREAMS(2), .NUM_INPUTS(3), .DIV_W(3), .CNT_W(2), .STABLE_N(3)
  ) u_dut_b (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .div_cfg(b_div_cfg), .start(start), .mode(mode), .reg_in(b_reg_in),
    .state(b_state), .stable(b_stable), .toggles(b_toggles)
  );

  // Per-instance configuration of the reference model.
  int p_ni[2]   = '{1, 3};
  int p_divw[2] = '{4, 3};
  int p_cntw[2] = '{8, 2};
  int p_sn[2]   = '{4, 3};

  int m_state[2][2];
  int m_div[2][2];
  int m_phase[2][2];
  int m_tog[2][2];
  int m_scnt[2][2];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int get_div(int i, int s);
    if (i == 0) return int'(a_div_cfg[s*4 +: 4]);
    return int'(b_div_cfg[s*3 +: 3]);
  endfunction

  function automatic int get_ones(int i, int s);
    if (i == 0) return int'(a_reg_in[s]);
    return $countones(b_reg_in[s*3 +: 3]);
  endfunction

  // Reference behaviour for one rising edge, from the block's rules.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (rst) begin
          m_state[i][s] = 0; m_div[i][s] = 0; m_phase[i][s] = 0;
          m_tog[i][s]   = 0; m_scnt[i][s] = 0;
        end else if (reset_nos) begin
          m_state[i][s] = int'(init_state[s]);
          m_div[i][s]   = get_div(i, s);
          m_phase[i][s] = m_div[i][s];
          m_tog[i][s]   = 0;
          m_scnt[i][s]  = 0;
        end else if (start[s]) begin
          if (m_phase[i][s] == m_div[i][s]) begin
            int k;
            int n;
            int nxt;
            k = get_ones(i, s);
            n = p_ni[i];
            case (int'(mode))
              0:       nxt = (k == 0) ? 1 : 0;
              1:       nxt = (k == n) ? 1 : 0;
              2:       nxt = (k > 0)  ? 1 : 0;
              default: nxt = (k != n) ? 1 : 0;
            endcase
            if (nxt != m_state[i][s]) begin
              if (m_tog[i][s] < (1 << p_cntw[i]) - 1) m_tog[i][s]++;
              m_scnt[i][s] = 0;
            end else if (m_scnt[i][s] < p_sn[i]) begin
              m_scnt[i][s]++;
            end
            m_state[i][s] = nxt;
            m_phase[i][s] = 0;
          end else begin
            m_phase[i][s] = (m_phase[i][s] + 1) % (1 << p_divw[i]);
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("a_state%0d", s),   int'(a_state[s]),          m_state[0][s]);
      check($sformatf("a_stable%0d", s),  int'(a_stable[s]),         (m_scnt[0][s] == p_sn[0]) ? 1 : 0);
      check($sformatf("a_toggles%0d", s), int'(a_toggles[s*8 +: 8]), m_tog[0][s]);
      check($sformatf("b_state%0d", s),   int'(b_state[s]),          m_state[1][s]);
      check($sformatf("b_stable%0d", s),  int'(b_stable[s]),         (m_scnt[1][s] == p_sn[1]) ? 1 : 0);
      check($sformatf("b_toggles%0d", s), int'(b_toggles[s*2 +: 2]), m_tog[1][s]);
    end
  endtask

  // One clock: inputs already driven, model advances on the edge, outputs
  // are compared 1 ns later, then the single-cycle strobes are dropped.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    start     = '0;
    reset_nos = 1'b0;
  endtask

  task automatic do_reset_nos(input logic [1:0] init, input logic [7:0] adiv,
                              input logic [5:0] bdiv);
    init_state = init;
    a_div_cfg  = adiv;
    b_div_cfg  = bdiv;
    reset_nos  = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; reset_nos = 1'b0; init_state = '0; start = '0; mode = '0;
    a_div_cfg = '0; a_reg_in = '0; b_div_cfg = '0; b_reg_in = '0;
    tick();
    tick();
    check("rst_state",   int'({b_state, a_state}),     0);
    check("rst_toggles", int'({b_toggles, a_toggles}), 0);
    rst = 1'b0;

    // Divider pattern: stream1 div 0, stream0 div 1, NOT of 0.
    mode = 2'd0; a_reg_in = 2'b00; b_reg_in = '0;
    do_reset_nos(2'b00, {4'd0, 4'd1}, 6'd0);
    start = 2'b11; tick();
    check("div_s1_first", int'(a_state[1]), 1);
    check("div_s0_first", int'(a_state[0]), 1);
    for (int k = 0; k < 3; k++) begin start = 2'b11; tick(); end
    check("div_toggles", int'(a_toggles), 16'h0101);

    // Mode sweep on the 3-input instance with slice 3'b011.
    b_reg_in = {3'b011, 3'b011};
    do_reset_nos(2'b00, 8'd0, 6'd0);
    for (int m = 0; m < 4; m++) begin
      logic [3:0] exp_tab;
      exp_tab = 4'b1100;
      mode  = 2'(m);
      start = 2'b11;
      tick();
      check($sformatf("mode%0d_state", m), int'(b_state[0]), int'(exp_tab[m]));
    end

    // Stability: 1 change, then 4 unchanged updates.
    mode = 2'd0; a_reg_in = 2'b00; b_reg_in = '0;
    do_reset_nos(2'b00, 8'd0, 6'd0);
    for (int k = 1; k <= 5; k++) begin
      start = 2'b11; tick();
      check($sformatf("stable_after_%0d", k), int'(a_stable), (k == 5) ? 3 : 0);
    end
    a_reg_in = 2'b11; start = 2'b11; tick();
    check("stable_drop", int'(a_stable), 0);
    check("toggle_after_flip", int'(a_toggles[7:0]), 2);

    // Toggle saturation on the 2-bit counter with an oscillating input.
    mode = 2'd2;
    do_reset_nos(2'b00, 8'd0, 6'd0);
    for (int k = 1; k <= 5; k++) begin
      b_reg_in = (k % 2 == 1) ? 6'b111111 : 6'b000000;
      start = 2'b11; tick();
      check($sformatf("sat_toggles_%0d", k), int'(b_toggles[1:0]), (k < 3) ? k : 3);
    end

    // reset_nos coincident with start: load only.
    init_state = 2'b10; a_div_cfg = '0; b_div_cfg = '0;
    reset_nos = 1'b1; start = 2'b11; tick();
    check("nos_start_state", int'(a_state), 2);
    check("nos_start_tog",   int'(b_toggles), 0);

    // rst overrides reset_nos and start.
    rst = 1'b1; reset_nos = 1'b1; init_state = 2'b11; start = 2'b11; tick();
    check("rst_over_state",  int'({b_state, a_state}), 0);
    check("rst_over_stable", int'({b_stable, a_stable}), 0);
    rst = 1'b0;
    // Post-reset divider behaves as 0: every start updates.
    mode = 2'd0; a_reg_in = 2'b00;
    start = 2'b11; tick();
    check("post_rst_update", int'(a_state), 3);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst        = (r == 0);
      reset_nos  = (r >= 1 && r < 6);
      init_state = 2'($urandom);
      a_div_cfg  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      b_div_cfg  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      start      = 2'($urandom);
      mode       = 2'($urandom);
      a_reg_in   = 2'($urandom);
      b_reg_in   = 6'($urandom);
      tick();
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gnr_node_array.md
GNR_NODE_ARRAY -- requirements
Module: gnr_node_array

Interface
REQ-001 The block SHALL have parameter NUM_STREAMS, default 2: number of independent state streams.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 1: regulator inputs per stream.
REQ-003 The block SHALL have parameter DIV_W, default 4: width of the per-stream update divider.
REQ-004 The block SHALL have parameter CNT_W, default 8: width of the per-stream toggle counter.
REQ-005 The block SHALL have parameter STABLE_N, default 4: consecutive non-changing updates needed to flag stability (1..255).
REQ-006 The block SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 The block SHALL have port reset_nos, input, 1: network re-initialise strobe.
REQ-009 The block SHALL have port init_state, input, NUM_STREAMS: per-stream initial state, loaded on reset_nos.
REQ-010 The block SHALL have port div_cfg, input, NUM_STREAMS*DIV_W: per-stream divider, stream s at [s*DIV_W +: DIV_W], latched on reset_nos.
REQ-011 The block SHALL have port start, input, NUM_STREAMS: per-stream update request, single-cycle pulse.
REQ-012 The block SHALL have port mode, input, 2: node function select.
REQ-013 The block SHALL have port reg_in, input, NUM_STREAMS*NUM_INPUTS: regulator states, stream s at [s*NUM_INPUTS +: NUM_INPUTS].
REQ-014 The block SHALL have port state, output, NUM_STREAMS: registered node state per stream.
REQ-015 The block SHALL have port stable, output, NUM_STREAMS: registered per-stream steady-state flag.
REQ-016 The block SHALL have port toggles, output, NUM_STREAMS*CNT_W: per-stream state-change count, stream s at [s*CNT_W +: CNT_W].

Function
REQ-017 Priority per cycle SHALL be rst > reset_nos > start; streams SHALL be fully independent except for the shared rst, reset_nos and mode.
REQ-018 On reset_nos, each stream SHALL load state=init_state[s], div_reg=div_cfg[s], phase=div_cfg[s], toggles=0, stable_cnt=0, and stable=0.
REQ-019 On start[s], if phase==div_reg, the stream SHALL perform an update and set phase=0; otherwise it SHALL set phase=phase+1 and hold state.
REQ-020 As a consequence of REQ-019, the first start after reset_nos SHALL update, and updates SHALL then occur on every (div_reg+1)-th start; div_reg=0 SHALL update on every start.
REQ-021 The update next-state SHALL be selected by mode, sampled in the update cycle, over x=reg_in slice: 0 = NOR(x), 1 = AND(x), 2 = OR(x), 3 = NAND(x).
REQ-022 With NUM_INPUTS=1, mode 0 SHALL equal NOT(x).
REQ-023 Updated state SHALL be visible on state one cycle after the start edge (registered, latency 1).
REQ-024 On an update where the new state differs from the old, toggles SHALL increment, saturating at 2^CNT_W-1; stable_cnt SHALL clear and stable SHALL drop in the same edge.
REQ-025 On an update with no state change, stable_cnt SHALL increment, saturating at STABLE_N.
REQ-026 stable SHALL be asserted when stable_cnt==STABLE_N.
REQ-027 A non-updating start (phase advance only) SHALL NOT affect toggles, stable_cnt or stable.
REQ-028 With start[s]=0 and no reset_nos, all stream-s registers SHALL hold.
REQ-029 reset_nos coincident with start SHALL perform only the reset_nos load.
REQ-030 A phase increment SHALL wrap modulo 2^DIV_W; this case is unreachable while phase<=div_reg.
REQ-031 A change of div_cfg SHALL take effect only at the next reset_nos.

Reset
REQ-032 While rst=1, all of state, stable, toggles, phase, div_reg and stable_cnt SHALL be 0, and the block SHALL behave after rst deasserts as if div_reg=0 (update on every start).
REQ-033 rst asserted mid-operation SHALL override reset_nos and start in the same cycle.

Verification
REQ-034 NUM_STREAMS=2, NUM_INPUTS=1, mode=0, reg_in=0; reset_nos with init=2'b00 and div_cfg={0,1}; then start=2'b11 for 4 cycles -> stream1 state 1 after the 1st start; stream0 updates on starts 1 and 3 only; toggles={1,1}.
REQ-035 NUM_INPUTS=3, reg_in slice 3'b011, stream updated on consecutive starts while mode is cycled through 0, 1, 2, 3 -> state 0, 0, 1, 1 respectively, one cycle after each start.
REQ-036 STABLE_N=4, constant reg_in, div_cfg=0, 5 starts -> stable rises one cycle after the 5th start (the 1st start changes state; the next 4 do not); flipping reg_in then starting -> stable=0 and toggles increments.
REQ-037 CNT_W=2, oscillating input forcing a change on 5 updates -> toggles reads 1, 2, 3, 3, 3 (saturates).
REQ-038 reset_nos and start pulsed in the same cycle -> init_state loaded, no update; rst asserted with reset_nos -> all outputs 0.
